// File: rtl/mshr_pkg.sv
// Shared types and constants for the MSHR file.
// Entry state encoding and line-address helper.
package mshr_pkg;

    localparam int N_ENTRIES   = 8;
    localparam int IDX_BITS    = 3;
    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 4;
    localparam int LINE_BITS   = 128;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SEL     = 2'd2,
        ST_WAIT    = 2'd3
    } mshr_state_e;

    localparam logic [ADDR_BITS-1:0] LINE_MASK =
        ~((ADDR_BITS'(1) << OFFSET_BITS) - ADDR_BITS'(1));

    function automatic logic [ADDR_BITS-1:0] line_of(
        input logic [ADDR_BITS-1:0] addr
    );
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/mshr_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
// Used for FREE-entry allocation and PENDING-entry issue.
module mshr_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mshr_file.sv
// Miss status holding registers: line-granular merge/allocate,
// single-entry memory request register and fill completion.
module mshr_file
    import mshr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [ADDR_BITS-1:0] alloc_addr,
    output logic                 alloc_ready,
    output logic                 alloc_merged,
    output logic [IDX_BITS-1:0]  mshr_wr_idx,
    output logic                 mshr_full,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [IDX_BITS-1:0]  mem_req_idx,
    input  logic                 mem_resp_valid,
    input  logic [IDX_BITS-1:0]  mem_resp_idx,
    input  logic [LINE_BITS-1:0] mem_resp_data,
    output logic                 mshr_fin,
    output logic [IDX_BITS-1:0]  mshr_fin_idx,
    output logic [ADDR_BITS-1:0] fill_addr,
    output logic [LINE_BITS-1:0] fill_data
);

    mshr_state_e          st_q   [N_ENTRIES];
    mshr_state_e          st_d   [N_ENTRIES];
    logic [ADDR_BITS-1:0] line_q [N_ENTRIES];

    logic [N_ENTRIES-1:0] free_vec;
    logic [N_ENTRIES-1:0] pend_vec;
    logic [N_ENTRIES-1:0] hit_vec;
    logic [IDX_BITS-1:0]  free_idx;
    logic [IDX_BITS-1:0]  pend_idx;
    logic [IDX_BITS-1:0]  hit_idx;
    logic                 free_found;
    logic                 pend_found;
    logic                 merge_hit;
    logic                 resp_hit;
    logic                 do_alloc;
    logic                 do_issue;
    logic                 do_accept;
    logic [ADDR_BITS-1:0] alloc_line;

    assign alloc_line = line_of(alloc_addr);
    assign resp_hit   = mem_resp_valid
                      && (st_q[mem_resp_idx] == ST_WAIT);

    // An entry completing this cycle must not absorb a new miss.
    always_comb begin
        free_vec = '0;
        pend_vec = '0;
        hit_vec  = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            free_vec[i] = (st_q[i] == ST_FREE);
            pend_vec[i] = (st_q[i] == ST_PENDING);
            hit_vec[i]  = (st_q[i] != ST_FREE)
                       && (line_q[i] == alloc_line)
                       && !(resp_hit
                            && mem_resp_idx == IDX_BITS'(i));
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = IDX_BITS'(i);
        end
    end

    mshr_prio_enc #(.N(N_ENTRIES), .W(IDX_BITS)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    mshr_prio_enc #(.N(N_ENTRIES), .W(IDX_BITS)) u_pend_enc (
        .req   (pend_vec),
        .idx   (pend_idx),
        .found (pend_found)
    );

    assign merge_hit    = |hit_vec;
    assign alloc_merged = alloc_valid && merge_hit;
    assign alloc_ready  = alloc_valid && (merge_hit || free_found);
    assign mshr_wr_idx  = merge_hit  ? hit_idx :
                          free_found ? free_idx : '0;
    assign mshr_full    = !free_found;

    assign do_alloc  = alloc_valid && !merge_hit && free_found;
    assign do_issue  = !mem_req_valid && pend_found;
    assign do_accept = mem_req_valid && mem_req_ready;

    // The four transitions always target distinct entries.
    always_comb begin
        st_d = st_q;
        if (do_alloc)  st_d[free_idx]     = ST_PENDING;
        if (do_issue)  st_d[pend_idx]     = ST_SEL;
        if (do_accept) st_d[mem_req_idx]  = ST_WAIT;
        if (resp_hit)  st_d[mem_resp_idx] = ST_FREE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                st_q[i]   <= ST_FREE;
                line_q[i] <= '0;
            end
        end else begin
            st_q <= st_d;
            if (do_alloc) line_q[free_idx] <= alloc_line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_idx   <= '0;
        end else if (do_accept) begin
            mem_req_valid <= 1'b0;
        end else if (do_issue) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= line_q[pend_idx];
            mem_req_idx   <= pend_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mshr_fin     <= 1'b0;
            mshr_fin_idx <= '0;
            fill_addr    <= '0;
            fill_data    <= '0;
        end else begin
            mshr_fin <= resp_hit;
            if (resp_hit) begin
                mshr_fin_idx <= mem_resp_idx;
                fill_addr    <= line_q[mem_resp_idx];
                fill_data    <= mem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mshr_file.sv
// Directed bench for mshr_file with a per-cycle reference model.
module tb_mshr_file;
    import mshr_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 alloc_valid = 1'b0;
    logic [ADDR_BITS-1:0] alloc_addr = '0;
    logic                 alloc_ready;
    logic                 alloc_merged;
    logic [IDX_BITS-1:0]  mshr_wr_idx;
    logic                 mshr_full;
    logic                 mem_req_valid;
    logic                 mem_req_ready = 1'b0;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [IDX_BITS-1:0]  mem_req_idx;
    logic                 mem_resp_valid = 1'b0;
    logic [IDX_BITS-1:0]  mem_resp_idx = '0;
    logic [LINE_BITS-1:0] mem_resp_data = '0;
    logic                 mshr_fin;
    logic [IDX_BITS-1:0]  mshr_fin_idx;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [LINE_BITS-1:0] fill_data;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    mshr_file dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_addr     (alloc_addr),
        .alloc_ready    (alloc_ready),
        .alloc_merged   (alloc_merged),
        .mshr_wr_idx    (mshr_wr_idx),
        .mshr_full      (mshr_full),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_idx    (mem_req_idx),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_idx   (mem_resp_idx),
        .mem_resp_data  (mem_resp_data),
        .mshr_fin       (mshr_fin),
        .mshr_fin_idx   (mshr_fin_idx),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: 0 free, 1 waiting to issue, 2 in request reg, 3 outstanding.
    int             m_st   [8];
    logic [31:0]    m_line [8];
    bit             m_rv;
    logic [31:0]    m_ra;
    int             m_ri;
    bit             m_fin;
    int             m_fi;
    logic [31:0]    m_fa;
    logic [127:0]   m_fd;

    function automatic logic [31:0] lineof(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    function automatic bit model_resp_ok();
        return mem_resp_valid && m_st[int'(mem_resp_idx)] == 3;
    endfunction

    function automatic void model_alloc(output bit ok, output bit mg,
                                        output int idx);
        bit rok = model_resp_ok();
        ok = 0; mg = 0; idx = 0;
        for (int j = 0; j < 8; j++)
            if (!mg && m_st[j] != 0 && m_line[j] == lineof(alloc_addr)
                && !(rok && int'(mem_resp_idx) == j)) begin
                mg = 1; idx = j;
            end
        if (mg) ok = 1;
        else
            for (int j = 0; j < 8; j++)
                if (!ok && m_st[j] == 0) begin ok = 1; idx = j; end
    endfunction

    bit mu_ok, mu_mg, mu_rok;
    int mu_ai, mu_pi;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 8; j++) begin m_st[j] = 0; m_line[j] = 0; end
            m_rv = 0; m_ra = 0; m_ri = 0;
            m_fin = 0; m_fi = 0; m_fa = 0; m_fd = 0;
        end else begin
            model_alloc(mu_ok, mu_mg, mu_ai);
            mu_rok = model_resp_ok();
            mu_pi = -1;
            for (int j = 0; j < 8; j++)
                if (mu_pi < 0 && m_st[j] == 1) mu_pi = j;
            if (m_rv && mem_req_ready) begin
                m_st[m_ri] = 3; m_rv = 0;
            end else if (!m_rv && mu_pi >= 0) begin
                m_st[mu_pi] = 2; m_rv = 1;
                m_ra = m_line[mu_pi]; m_ri = mu_pi;
            end
            if (alloc_valid && mu_ok && !mu_mg) begin
                m_st[mu_ai] = 1; m_line[mu_ai] = lineof(alloc_addr);
            end
            if (mu_rok) begin
                m_fin = 1; m_fi = int'(mem_resp_idx);
                m_fa = m_line[m_fi]; m_fd = mem_resp_data;
                m_st[m_fi] = 0;
            end else m_fin = 0;
        end
    end

    bit cm_ok, cm_mg, cm_full;
    int cm_idx;

    always @(negedge clk) begin
        cm_full = 1;
        for (int j = 0; j < 8; j++) if (m_st[j] == 0) cm_full = 0;
        check("m_full", mshr_full, cm_full);
        check("m_req_valid", mem_req_valid, m_rv);
        if (m_rv) begin
            check("m_req_addr", mem_req_addr, m_ra);
            check("m_req_idx", mem_req_idx, m_ri[2:0]);
        end
        check("m_fin", mshr_fin, m_fin);
        check("m_fin_idx", mshr_fin_idx, m_fi[2:0]);
        check("m_fill_addr", fill_addr, m_fa);
        check("m_fill_data", fill_data, m_fd);
        if (rst && alloc_valid) begin
            model_alloc(cm_ok, cm_mg, cm_idx);
            check("m_alloc_ready", alloc_ready, cm_ok);
            check("m_alloc_merged", alloc_merged, cm_mg);
            check("m_wr_idx", mshr_wr_idx, cm_idx[2:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_chk(input logic [31:0] a, input bit rdy,
                             input bit mg, input int idx);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        #1;
        check("alloc_ready", alloc_ready, rdy);
        check("alloc_merged", alloc_merged, mg);
        check("wr_idx", mshr_wr_idx, idx[2:0]);
    endtask

    task automatic chk_req(input string nm, input bit v,
                           input logic [31:0] a, input int idx);
        check({nm, "_valid"}, mem_req_valid, v);
        if (v) begin
            check({nm, "_addr"}, mem_req_addr, a);
            check({nm, "_idx"}, mem_req_idx, idx[2:0]);
        end
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_req_valid"}, mem_req_valid, 1'b0);
        check({nm, "_req_addr"}, mem_req_addr, 32'h0);
        check({nm, "_req_idx"}, mem_req_idx, 3'h0);
        check({nm, "_fin"}, mshr_fin, 1'b0);
        check({nm, "_fin_idx"}, mshr_fin_idx, 3'h0);
        check({nm, "_fill_addr"}, fill_addr, 32'h0);
        check({nm, "_fill_data"}, fill_data, 128'h0);
        check({nm, "_full"}, mshr_full, 1'b0);
    endtask

    initial begin
        tick(); tick();
        chk_zero("rst0");
        rst = 1'b1;
        tick();

        // first allocation and its latency
        alloc_chk(32'h1000, 1, 0, 0);
        tick(); alloc_valid = 1'b0;
        chk_req("lat1", 0, 0, 0);
        tick();
        chk_req("lat2", 1, 32'h1000, 0);
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        chk_req("acc", 0, 0, 0);
        mem_resp_valid = 1'b1; mem_resp_idx = 3'd0;
        mem_resp_data = 128'h1111;
        tick(); mem_resp_valid = 1'b0;
        check("fin_a", mshr_fin, 1'b1);
        check("fill_a", fill_addr, 32'h1000);
        tick();
        check("fin_a_end", mshr_fin, 1'b0);
        check("fill_a_hold", fill_addr, 32'h1000);

        // merge into one line
        alloc_chk(32'h2004, 1, 0, 0); tick();
        alloc_chk(32'h200C, 1, 1, 0); tick();
        alloc_valid = 1'b0;
        chk_req("mrg", 1, 32'h2000, 0);
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        repeat (3) tick();
        chk_req("mrg_once", 0, 0, 0);
        mem_resp_valid = 1'b1; mem_resp_idx = 3'd0;
        mem_resp_data = 128'h2222;
        tick(); mem_resp_valid = 1'b0;
        check("fin_m", mshr_fin, 1'b1);
        tick();

        // fill all entries
        for (int i = 0; i < 8; i++) begin
            alloc_chk(32'h3000 + 32'(i) * 32'h100, 1, 0, i);
            tick();
        end
        alloc_chk(32'h9000, 0, 0, 0);
        check("full", mshr_full, 1'b1);
        alloc_chk(32'h3008, 1, 1, 0);
        alloc_chk(32'h3508, 1, 1, 5);
        alloc_valid = 1'b0;

        // backpressure
        chk_req("bp0", 1, 32'h3000, 0);
        repeat (5) begin
            tick();
            chk_req("bp_hold", 1, 32'h3000, 0);
        end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        chk_req("bp_gap", 0, 0, 0);
        tick();
        chk_req("bp_next", 1, 32'h3100, 1);
        mem_req_ready = 1'b1;
        repeat (4) tick();
        mem_req_ready = 1'b0;
        chk_req("bp_e3", 1, 32'h3300, 3);

        // fill entry 2 with same-line allocation in flight
        mem_resp_valid = 1'b1; mem_resp_idx = 3'd2; mem_resp_data = DEAD;
        alloc_chk(32'h3208, 0, 0, 0);
        check("full_sticky", mshr_full, 1'b1);
        tick(); mem_resp_valid = 1'b0;
        check("fin_f", mshr_fin, 1'b1);
        check("fin_idx_f", mshr_fin_idx, 3'd2);
        check("fill_addr_f", fill_addr, 32'h3200);
        check("fill_data_f", fill_data, DEAD);
        check("full_clr", mshr_full, 1'b0);
        alloc_chk(32'h3208, 1, 0, 2);
        tick(); alloc_valid = 1'b0;
        check("fin_f_end", mshr_fin, 1'b0);
        check("fill_f_hold", fill_data, DEAD);
        check("full_again", mshr_full, 1'b1);

        // reset mid-traffic, then stray responses
        rst = 1'b0; #1;
        chk_zero("rst1");
        tick(); rst = 1'b1; tick();
        mem_resp_valid = 1'b1; mem_resp_idx = 3'd0; mem_resp_data = DEAD;
        tick();
        check("stale_fin", mshr_fin, 1'b0);
        mem_resp_idx = 3'd5;
        tick(); mem_resp_valid = 1'b0;
        check("stray_fin", mshr_fin, 1'b0);
        check("stray_fill", fill_addr, 32'h0);
        alloc_chk(32'h1000, 1, 0, 0);
        tick(); alloc_valid = 1'b0; tick();
        chk_req("post_rst", 1, 32'h1000, 0);
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_idx = 3'd0;
        mem_resp_data = 128'h3333;
        tick();
        check("fin_r", mshr_fin, 1'b1);
        tick(); mem_resp_valid = 1'b0;
        check("dup_fin", mshr_fin, 1'b0);
        check("dup_hold", fill_data, 128'h3333);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mshr_file.md
Name: mshr_file

Overview:
- Miss Status Holding Register file sitting beside the cache and directly upstream of the LSQ.
- On a cache miss it allocates (or merges into) a line-granular entry and returns the entry index the LSQ records as mshr_wr_idx.
- It issues one memory line request per entry and accepts the fill response.
- On fill it pulses mshr_fin/mshr_fin_idx, which wake the LSQ entries waiting on that index.

Parameters:
N_ENTRIES, 8, number of MSHR entries.
IDX_BITS, 3, entry index width; equals log2(N_ENTRIES) and matches the LSQ mshr index width.
ADDR_BITS, 32, byte address width.
OFFSET_BITS, 4, line offset bits (16-byte line).
LINE_BITS, 128, fill data width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
alloc_valid  in  1  cache reports a miss this cycle.
alloc_addr  in  ADDR_BITS  miss byte address.
alloc_ready  out  1  combinational; allocation or merge is accepted this cycle.
alloc_merged  out  1  combinational; the miss matched an already-outstanding line.
mshr_wr_idx  out  IDX_BITS  combinational; entry index for this miss (valid when alloc_valid && alloc_ready).
mshr_full  out  1  registered-state-derived; all entries non-FREE.
mem_req_valid  out  1  registered line request to memory.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  ADDR_BITS  line-aligned address; low OFFSET_BITS are 0.
mem_req_idx  out  IDX_BITS  entry tag carried with the request.
mem_resp_valid  in  1  fill data return.
mem_resp_idx  in  IDX_BITS  entry tag of the fill.
mem_resp_data  in  LINE_BITS  fill line.
mshr_fin  out  1  registered one-cycle pulse: the entry completed.
mshr_fin_idx  out  IDX_BITS  completed entry index.
fill_addr  out  ADDR_BITS  line address of the completed entry, to the cache.
fill_data  out  LINE_BITS  registered fill line, to the cache.

Behaviour:
- Entry state, 2 bits: FREE, PENDING (awaiting issue), SEL (loaded in request register), WAIT (request accepted). Each entry also stores a line address.
- Reset (rst=0, async): all entries FREE, request register empty. mem_req_valid=0, mshr_fin=0. mem_req_addr, mem_req_idx, mshr_fin_idx, fill_addr, fill_data = 0.
- Merge check: alloc_addr line compared against every non-FREE entry.
  - Exception: an entry receiving a valid fill this cycle is excluded from the merge check.
  - On a hit: alloc_merged=1, alloc_ready=1, mshr_wr_idx = hit index, no state change.
- Allocation (no merge hit):
  - Lowest-index FREE entry is chosen. mshr_wr_idx = that index, alloc_ready=1.
  - At the edge: entry -> PENDING, line address stored.
  - If no FREE entry: alloc_ready=0, mshr_wr_idx=0, no state change.
- An entry freed by a fill this cycle is not available for allocation until the next cycle.
- Issue:
  - When the request register is empty and any entry is PENDING, at the edge the lowest-index PENDING entry -> SEL and loads mem_req_addr/mem_req_idx; mem_req_valid=1.
  - mem_req_valid, mem_req_addr and mem_req_idx are held stable until mem_req_ready.
  - On valid && ready: entry SEL -> WAIT and the register empties. The register is not reloaded in the same cycle, so at most one request every 2 cycles.
- Latency: allocation at edge N -> mem_req_valid high after edge N+1, at the earliest.
- Fill:
  - mem_resp_valid with mem_resp_idx in WAIT: at the edge, entry -> FREE; mshr_fin=1, mshr_fin_idx=idx, fill_addr=line address, fill_data=mem_resp_data.
  - mshr_fin deasserts the next cycle unless another fill arrives.
  - fill_* hold their last value when mshr_fin=0.
- A response to an entry not in WAIT is ignored: no fin, no state change.
- Simultaneous events in one cycle (allocation, issue handshake, fill, all to different entries) are all applied.
- Allocation while a response hits the same line: a new entry is allocated.
- mshr_full is computed from current state only. Same-cycle frees do not clear it until the next cycle.
- Reset mid-operation drops all outstanding entries. Later responses are ignored because their entries are not in WAIT.

Decomposition:
- Package mshr_pkg: entry state encoding (FREE/PENDING/SEL/WAIT); N_ENTRIES/IDX_BITS/OFFSET_BITS/LINE_BITS defaults; a line-address extraction function.
- Sub-module mshr_prio_enc: lowest-set-bit index plus found flag over N_ENTRIES bits. It is instantiated twice: FREE vector for allocation, PENDING vector for issue.

Test Plan:
- Reset: rst=0 mid-traffic -> all outputs 0; then allocate 0x1000 -> mshr_wr_idx=0, merged=0; mem_req_valid after 2 edges with addr 0x1000, idx 0.
- Merge: allocate 0x2004, then 0x200C -> both return idx 0; second alloc_merged=1; exactly one mem request, addr 0x2000.
- Full: allocate 8 distinct lines -> idx 0..7, mshr_full=1; ninth distinct line -> alloc_ready=0; a ninth address in line 0x3000 (already held) still merges with alloc_ready=1.
- Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid/addr/idx stable; ready=1 -> next request no earlier than 2 cycles later, lowest PENDING index.
- Fill: response idx 2, data 0xDEAD... -> next cycle mshr_fin=1, mshr_fin_idx=2, fill_addr = entry 2 line; one-cycle pulse; entry 2 reused only the following cycle.
- Stray response: mem_resp_idx=5 while entry 5 is FREE, and a duplicate response to an already-freed entry -> no mshr_fin, state unchanged.
